// File: rtl/bsg_dff_lanestack.sv
`default_nettype none
// ============================================================================
// Module      : bsg_dff_lanestack
// Description : Bank of LANES independent shift-register lanes on one clock.
//               Each lane advances on its own strobe, which is either the
//               en_i level (EDGE_MODE=0) or the rising edge of en_i sampled
//               on clk_i (EDGE_MODE=1). Every lane is DEPTH stages deep,
//               tracks a saturating occupancy count and has a synchronous
//               clear that overrides a simultaneous strobe.
// Ports       : clk_i    - clock, all state updates on posedge
//               reset_i  - asynchronous active-high reset
//               en_i     - per-lane advance enable
//               clear_i  - per-lane synchronous clear
//               data_i   - lane i at [i*LANE_WIDTH +: LANE_WIDTH]
//               data_o   - last stage of each lane (registered)
//               v_o      - lane full (count == DEPTH)
//               count_o  - per-lane occupancy, lane i at [i*CW +: CW]
// Revision    : 1.0 - initial release
// ============================================================================
module bsg_dff_lanestack #(
    parameter int LANES      = 16,
    parameter int LANE_WIDTH = 1,
    parameter int DEPTH      = 1,
    parameter int EDGE_MODE  = 0
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic [LANES-1:0]                    en_i,
    input  logic [LANES-1:0]                    clear_i,
    input  logic [LANES*LANE_WIDTH-1:0]         data_i,
    output logic [LANES*LANE_WIDTH-1:0]         data_o,
    output logic [LANES-1:0]                    v_o,
    output logic [LANES*$clog2(DEPTH+1)-1:0]    count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic C_EDGE = (EDGE_MODE == 1);

    if (LANES < 1 || LANE_WIDTH < 1 || DEPTH < 1 || (EDGE_MODE != 0 && EDGE_MODE != 1))
    begin : g_bad_params
        $error("bsg_dff_lanestack: illegal parameter combination");
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [LANE_WIDTH-1:0] r_stage [DEPTH];
        logic [CW-1:0]         r_count;
        logic                  r_en;
        logic                  w_strobe;

        // In level mode the previous-enable term is forced true, so the
        // same register serves both modes without a separate datapath.
        assign w_strobe = en_i[l] & (~C_EDGE | ~r_en);

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                for (int k = 0; k < DEPTH; k++) begin
                    r_stage[k] <= '0;
                end
                r_count <= '0;
                r_en    <= 1'b0;
            end else begin
                // Edge history follows en_i every cycle, clear or not.
                r_en <= en_i[l];
                if (clear_i[l]) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        r_stage[k] <= '0;
                    end
                    r_count <= '0;
                end else if (w_strobe) begin
                    r_stage[0] <= data_i[l*LANE_WIDTH +: LANE_WIDTH];
                    for (int k = 1; k < DEPTH; k++) begin
                        r_stage[k] <= r_stage[k-1];
                    end
                    // Saturate at DEPTH; the shift continues and drops the
                    // oldest entry.
                    if (r_count != C_DEPTH) begin
                        r_count <= r_count + CW'(1);
                    end
                end
            end
        end

        assign data_o[l*LANE_WIDTH +: LANE_WIDTH] = r_stage[DEPTH-1];
        assign count_o[l*CW +: CW]                = r_count;
        assign v_o[l]                             = (r_count == C_DEPTH);
    end

endmodule
`default_nettype wire
